// File: rtl/usi_spi_pkg.sv
// Shared types and constants for the USI SPI master engine.
package usi_spi_pkg;

    localparam int unsigned SPI_FRAME_BITS   = 8;
    localparam int unsigned GAP_HALF_PERIODS = 2;
    localparam int unsigned BIT_CNT_W        = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    function automatic logic [SPI_FRAME_BITS-1:0] bit_reverse(input logic [SPI_FRAME_BITS-1:0] d);
        logic [SPI_FRAME_BITS-1:0] r;
        for (int i = 0; i < int'(SPI_FRAME_BITS); i++) begin
            r[i] = d[int'(SPI_FRAME_BITS) - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/usi_spi_clkgen.sv
// Half-period down-counter: reload on load, tc_c asserted on the last cycle of a phase.
module usi_spi_clkgen #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             tc_c
);

    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end

    assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/usi_spi_master.sv
// USI SPI master engine, mode 0, 8-bit frames with per-byte nss framing.
// Optional USI_SPI_MST_LSB_FIRST_EN adds the lsb_first input.
module usi_spi_master
    import usi_spi_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [7:0]       tx_data,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    output logic             busy,
    output logic             sclk_out,
    output logic             sclk_oe,
    output logic             mosi_out,
    output logic             mosi_oe,
    output logic             nss_out,
    output logic             nss_oe,
    input  logic             miso_in,
    output logic             miso_ie
`ifdef USI_SPI_MST_LSB_FIRST_EN
    ,
    input  logic             lsb_first
`endif
);

    spi_state_e                  state_q, state_d;
    logic [DIV_W-1:0]            div_q;
    logic [SPI_FRAME_BITS-2:0]   tx_sr;
    logic [SPI_FRAME_BITS-1:0]   rx_sr;
    logic [SPI_FRAME_BITS-1:0]   tx_first_c;
    logic [BIT_CNT_W-1:0]        bit_cnt_q;
    logic                        phase_first_q;
    logic                        lsb_q;
    logic                        lsb_in_c;
    logic                        accept_c, load_c, abort_c, tc_c;
    logic [DIV_W-1:0]            load_val_c;

`ifdef USI_SPI_MST_LSB_FIRST_EN
    assign lsb_in_c = lsb_first;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lsb_q <= 1'b0;
        end else if (accept_c) begin
            lsb_q <= lsb_first;
        end
    end
`else
    assign lsb_in_c = 1'b0;
    assign lsb_q    = 1'b0;
`endif

    assign sclk_oe    = en;
    assign mosi_oe    = en;
    assign nss_oe     = en;
    assign miso_ie    = en;
    assign accept_c   = (state_q == ST_IDLE) && tx_valid && tx_ready && en;
    assign load_val_c = (state_q == ST_IDLE) ? clk_div : div_q;
    assign tx_first_c = lsb_in_c ? bit_reverse(tx_data) : tx_data;

    usi_spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (load_c),
        .load_val (load_val_c),
        .tc_c     (tc_c)
    );

    // Next state; every phase change reloads the half-period counter.
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        abort_c = 1'b0;
        if (state_q != ST_IDLE && !en) begin
            abort_c = 1'b1;
            state_d = ST_GAP;
            load_c  = 1'b1;
        end else if (accept_c) begin
            state_d = ST_SETUP;
            load_c  = 1'b1;
        end else if (tc_c) begin
            case (state_q)
                ST_SETUP: state_d = ST_HIGH;
                ST_HIGH:  state_d = ST_LOW;
                ST_LOW:   state_d = (bit_cnt_q == BIT_CNT_W'(SPI_FRAME_BITS - 1)) ? ST_HOLD : ST_HIGH;
                ST_HOLD:  state_d = ST_GAP;
                ST_GAP:   state_d = (bit_cnt_q == BIT_CNT_W'(GAP_HALF_PERIODS - 1)) ? ST_IDLE : ST_GAP;
                default:  state_d = state_q;
            endcase
            load_c = (state_q != ST_IDLE) && (state_d != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            bit_cnt_q     <= '0;
            phase_first_q <= 1'b0;
            sclk_out      <= 1'b0;
            mosi_out      <= 1'b0;
            nss_out       <= 1'b1;
            tx_ready      <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_first_q <= load_c;
            rx_valid      <= 1'b0;
            sclk_out      <= (state_d == ST_HIGH);
            nss_out       <= !(state_d inside {ST_SETUP, ST_HIGH, ST_LOW, ST_HOLD});
            busy          <= (state_d != ST_IDLE);
            tx_ready      <= en && (state_d == ST_IDLE);

            if (accept_c) begin
                div_q     <= clk_div;
                tx_sr     <= tx_first_c[SPI_FRAME_BITS-2:0];
                mosi_out  <= tx_first_c[SPI_FRAME_BITS-1];
                bit_cnt_q <= '0;
            end else if (abort_c) begin
                bit_cnt_q <= '0;
            end else begin
                // Sample on the sclk rising edge, i.e. the first cycle of HIGH.
                if (state_q == ST_HIGH && phase_first_q) begin
                    rx_sr <= lsb_q ? {miso_in, rx_sr[SPI_FRAME_BITS-1:1]}
                                   : {rx_sr[SPI_FRAME_BITS-2:0], miso_in};
                end
                if (state_q == ST_HIGH && state_d == ST_LOW &&
                    bit_cnt_q != BIT_CNT_W'(SPI_FRAME_BITS - 1)) begin
                    mosi_out <= tx_sr[SPI_FRAME_BITS-2];
                    tx_sr    <= {tx_sr[SPI_FRAME_BITS-3:0], 1'b0};
                end
                if (state_q == ST_LOW && state_d != ST_LOW) begin
                    bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                end
                if (state_q == ST_HOLD && state_d == ST_GAP) begin
                    bit_cnt_q <= '0;
                    rx_valid  <= 1'b1;
                    rx_data   <= rx_sr;
                end
                if (state_q == ST_GAP && state_d == ST_GAP && tc_c) begin
                    bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_usi_spi_master.sv
// Scoreboard bench for usi_spi_master: loopback and slave-model frames, back-to-back, abort, reset.
module tb_usi_spi_master;

    logic       clk = 1'b0;
    logic       rst_b, en, tx_valid, tx_ready, rx_valid, busy;
    logic       sclk_out, sclk_oe, mosi_out, mosi_oe, nss_out, nss_oe, miso_in, miso_ie;
    logic [7:0] clk_div, tx_data, rx_data;
`ifdef USI_SPI_MST_LSB_FIRST_EN
    logic       lsb_first;
`endif
    logic       loop_en, slave_miso;
    logic [7:0] slave_sr, slave_byte;

    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    int         rx_count = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    assign miso_in = loop_en ? mosi_out : slave_miso;

    usi_spi_master #(.DIV_W(8)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .en       (en),
        .clk_div  (clk_div),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy),
        .sclk_out (sclk_out),
        .sclk_oe  (sclk_oe),
        .mosi_out (mosi_out),
        .mosi_oe  (mosi_oe),
        .nss_out  (nss_out),
        .nss_oe   (nss_oe),
        .miso_in  (miso_in),
        .miso_ie  (miso_ie)
`ifdef USI_SPI_MST_LSB_FIRST_EN
        ,
        .lsb_first(lsb_first)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Mode-0 slave: first bit out when nss falls, next bit on each falling sclk.
    always @(negedge nss_out) begin
        slave_sr   = slave_byte;
        slave_miso = slave_sr[7];
    end
    always @(negedge sclk_out) begin
        if (!nss_out) begin
            slave_sr   = {slave_sr[6:0], 1'b0};
            slave_miso = slave_sr[7];
        end
    end

    always @(negedge clk) begin
        if (rst_b === 1'b1 && rx_valid === 1'b1) begin
            rx_count++;
            if (sb.size() == 0) begin
                chk_cnt++;
                $display("FAIL rx_unexpected: rx_valid with rx_data=0x%02h, no byte expected", rx_data);
            end else begin
                check("rx_data", 32'(rx_data), 32'(sb.pop_front()));
            end
        end
    end

    // One complete frame with timing measured relative to the accept cycle.
    task automatic frame_measure(input logic [7:0] data, input logic [7:0] div,
                                 input logic [7:0] exp_mosi, input logic [7:0] exp_rx);
        int         h         = int'(div) + 1;
        int         nss_first = -1;
        int         nss_cnt   = 0;
        int         rise_cnt  = 0;
        int         rise_bad  = 0;
        int         hi_cnt    = 0;
        int         rx_j      = -1;
        int         rdy_j     = -1;
        logic [7:0] mosi_bits = 8'h00;
        logic       sclk_prev = 1'b0;
        @(negedge clk);
        check("ready_before_frame", 32'(tx_ready), 32'd1);
        tx_data  = data;
        clk_div  = div;
        tx_valid = 1'b1;
        sb.push_back(exp_rx);
        for (int j = 1; j <= 20 * h + 10 && rdy_j < 0; j++) begin
            @(negedge clk);
            if (j == 1) begin
                tx_valid = 1'b0;
                clk_div  = div ^ 8'h05;
            end
            if (!nss_out) begin
                nss_cnt++;
                if (nss_first < 0) nss_first = j;
            end
            if (sclk_out) hi_cnt++;
            if (sclk_out && !sclk_prev) begin
                if (j != 1 + h + 2 * h * rise_cnt) rise_bad++;
                rise_cnt++;
                mosi_bits = {mosi_bits[6:0], mosi_out};
            end
            sclk_prev = sclk_out;
            if (rx_valid && rx_j < 0) rx_j = j;
            if (tx_ready) rdy_j = j;
        end
        check("nss_first_low", 32'(nss_first), 32'd1);
        check("nss_low_cycles", 32'(nss_cnt), 32'(18 * h));
        check("sclk_rises", 32'(rise_cnt), 32'd8);
        check("sclk_rise_timing_errs", 32'(rise_bad), 32'd0);
        check("sclk_high_cycles", 32'(hi_cnt), 32'(8 * h));
        check("mosi_bits", 32'(mosi_bits), 32'(exp_mosi));
        check("rx_valid_cycle", 32'(rx_j), 32'(18 * h + 1));
        check("tx_ready_cycle", 32'(rdy_j), 32'(20 * h + 1));
    endtask

    initial begin
        int         rx0, rises, n, nacc, lr, nss_run, gap, seen_low;
        int         low_runs[$];
        logic       prev;
        rst_b      = 1'b0;
        en         = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        clk_div    = 8'h00;
        loop_en    = 1'b1;
        slave_miso = 1'b0;
        slave_byte = 8'h00;
`ifdef USI_SPI_MST_LSB_FIRST_EN
        lsb_first  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({sclk_out, nss_out, mosi_out, tx_ready, rx_valid, busy}), 32'b010000);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("oe_disabled", 32'({sclk_oe, mosi_oe, nss_oe, miso_ie}), 32'h0);
        en    = 1'b1;
        rst_b = 1'b1;
        #1;
        check("ready_at_release", 32'(tx_ready), 32'd0);
        check("oe_enabled", 32'({sclk_oe, mosi_oe, nss_oe, miso_ie}), 32'hF);
        @(negedge clk);
        check("ready_after_first_clk", 32'(tx_ready), 32'd1);

        // Loopback, H=4
        frame_measure(8'h12, 8'd3, 8'h12, 8'h12);

        // Slave answers 0xA5, H=1
        loop_en    = 1'b0;
        slave_byte = 8'hA5;
        frame_measure(8'h34, 8'd0, 8'h34, 8'hA5);
        loop_en    = 1'b1;

        // Back-to-back with tx_valid held, H=2
        nacc = 0; lr = 0; nss_run = 0; gap = -1; seen_low = 0;
        @(negedge clk);
        tx_data  = 8'h34;
        clk_div  = 8'd1;
        tx_valid = 1'b1;
        for (int j = 0; j < 110; j++) begin
            if (!tx_ready) lr++;
            else if (lr > 0) begin
                low_runs.push_back(lr);
                lr = 0;
            end
            if (!nss_out) begin
                if (seen_low != 0 && nss_run > 0 && gap < 0) gap = nss_run;
                seen_low = 1;
                nss_run  = 0;
            end else if (seen_low != 0) begin
                nss_run++;
            end
            if (tx_valid && tx_ready) begin
                nacc++;
                sb.push_back(nacc == 1 ? 8'h34 : 8'h56);
            end else if (nacc == 1) begin
                tx_data = 8'h56;
            end else if (nacc == 2) begin
                tx_valid = 1'b0;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("b2b_accepts", 32'(nacc), 32'd2);
        check("b2b_ready_runs", 32'(low_runs.size()), 32'd2);
        if (low_runs.size() == 2) begin
            check("b2b_ready_low_1", 32'(low_runs[0]), 32'd40);
            check("b2b_ready_low_2", 32'(low_runs[1]), 32'd40);
        end
        // 2H of GAP plus the idle accept cycle
        check("b2b_nss_gap", 32'(gap), 32'd5);

        // Abort after the 3rd rising edge, H=3
        rises = 0;
        prev  = 1'b0;
        @(negedge clk);
        tx_data  = 8'h9C;
        clk_div  = 8'd2;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        rx0 = rx_count;
        for (int k = 0; k < 100 && rises < 3; k++) begin
            if (sclk_out && !prev) rises++;
            prev = sclk_out;
            if (rises < 3) @(negedge clk);
        end
        check("abort_rises_seen", 32'(rises), 32'd3);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        check("abort_pins", 32'({sclk_out, nss_out, busy}), 32'b011);
        n = 1;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            if (!tx_ready) n++;
        end
        check("abort_gap_cycles", 32'(n), 32'd6);
        check("abort_no_rx", 32'(rx_count), 32'(rx0));

        // Asynchronous reset mid-frame, then a normal frame
        @(negedge clk);
        tx_data  = 8'h3C;
        clk_div  = 8'd1;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        rx0 = rx_count;
        for (int k = 0; k < 50 && !sclk_out; k++) @(negedge clk);
        check("rst_mid_sclk_high", 32'(sclk_out), 32'd1);
        rst_b = 1'b0;
        #1;
        check("rst_mid_outputs", 32'({sclk_out, nss_out, busy, tx_ready, rx_valid}), 32'b01000);
        check("rst_mid_rx_data", 32'(rx_data), 32'h00);
        @(negedge clk);
        rst_b = 1'b1;
        frame_measure(8'h78, 8'd2, 8'h78, 8'h78);
        check("rst_mid_rx_count", 32'(rx_count), 32'(rx0 + 1));

`ifdef USI_SPI_MST_LSB_FIRST_EN
        lsb_first = 1'b1;
        frame_measure(8'h12, 8'd3, 8'h48, 8'h12);
        lsb_first = 1'b0;
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
